// File: rtl/int2float_pipe.sv
// int2float_pipe: 3-stage integer to mini-float converter (M * 2^E).
// Valid/ready handshake, global stall, RNE or truncate, saturating exponent.
module int2float_pipe #(
    parameter int IN_W   = 11,
    parameter int MAN_W  = 4,
    parameter int EXP_W  = 3,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sign,
    output logic             out_ovf,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    // Internal exponent width: holds leading-one position plus a rounding carry.
    localparam int EW   = $clog2(IN_W + 1) + 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam logic [MAN_W-1:0] MAN_HALF = {1'b1, {(MAN_W-1){1'b0}}};

    logic stall;

    // Stage 1 state
    logic             v1_q;
    logic [IN_W-1:0]  mag1_q, mag1_d;
    logic             sgn1_q, sgn1_d;
    logic             rnd1_q;

    // Stage 2 state
    logic             v2_q;
    logic [MAN_W-1:0] man2_q, man2_d;
    logic [EW-1:0]    exp2_q, exp2_d;
    logic             r2_q, r2_d;
    logic             s2_q, s2_d;
    logic             rnd2_q;
    logic             sgn2_q;

    // Stage 3 (output) state
    logic             v3_q;
    logic [MAN_W-1:0] man3_q, man3_d;
    logic [EXP_W-1:0] exp3_q, exp3_d;
    logic             sgn3_q;
    logic             ovf3_q, ovf3_d;
    logic             sticky_q, sticky_d;

    // Stage-2/3 scratch
    logic [EW-1:0]    lead;
    logic [IN_W-1:0]  rmask;
    logic             inc;
    logic [MAN_W:0]   msum;
    logic [MAN_W-1:0] mfin;
    logic [EW-1:0]    efin;

    // Outputs are forced to their idle values while reset is held.
    assign out_valid  = v3_q & ~rst;
    assign out_man    = rst ? '0 : man3_q;
    assign out_exp    = rst ? '0 : exp3_q;
    assign out_sign   = sgn3_q & ~rst;
    assign out_ovf    = ovf3_q & ~rst;
    assign ovf_sticky = sticky_q & ~rst;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // S1 combinational: magnitude and sign of the operand.
    always_comb begin
        mag1_d = in_data;
        sgn1_d = 1'b0;
        if (SIGNED != 0) begin
            sgn1_d = in_data[IN_W-1];
            if (in_data[IN_W-1]) begin
                mag1_d = IN_W'(0) - in_data;
            end
        end
    end

    // S2 combinational: leading-one detect, shift, guard/sticky extraction.
    always_comb begin
        lead = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag1_q[i]) begin
                lead = EW'(i);
            end
        end
        exp2_d = '0;
        man2_d = mag1_q[MAN_W-1:0];
        rmask  = '0;
        r2_d   = 1'b0;
        s2_d   = 1'b0;
        if (|mag1_q[IN_W-1:MAN_W]) begin
            exp2_d = lead - EW'(MAN_W - 1);
            man2_d = MAN_W'(mag1_q >> exp2_d);
            rmask  = IN_W'(1) << (exp2_d - EW'(1));
            r2_d   = |(mag1_q & rmask);
            s2_d   = |(mag1_q & (rmask - IN_W'(1)));
        end
    end

    // S3 combinational: round, renormalise on carry, saturate.
    always_comb begin
        inc  = rnd2_q & r2_q & (s2_q | man2_q[0]);
        msum = {1'b0, man2_q} + {{MAN_W{1'b0}}, inc};
        mfin = msum[MAN_W-1:0];
        efin = exp2_q;
        if (msum[MAN_W]) begin
            mfin = MAN_HALF;
            efin = exp2_q + EW'(1);
        end
        man3_d = mfin;
        exp3_d = EXP_W'(efin);
        ovf3_d = 1'b0;
        if (int'(efin) > EMAX) begin
            man3_d = '1;
            exp3_d = '1;
            ovf3_d = 1'b1;
        end
    end

    // Stage 1 register: advances unless the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            mag1_q <= '0;
            sgn1_q <= 1'b0;
            rnd1_q <= 1'b0;
        end else if (!stall) begin
            v1_q   <= in_valid;
            mag1_q <= mag1_d;
            sgn1_q <= sgn1_d;
            rnd1_q <= in_rnd;
        end
    end

    // Stage 2 register: normalised mantissa and rounding bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q   <= 1'b0;
            man2_q <= '0;
            exp2_q <= '0;
            r2_q   <= 1'b0;
            s2_q   <= 1'b0;
            rnd2_q <= 1'b0;
            sgn2_q <= 1'b0;
        end else if (!stall) begin
            v2_q   <= v1_q;
            man2_q <= man2_d;
            exp2_q <= exp2_d;
            r2_q   <= r2_d;
            s2_q   <= s2_d;
            rnd2_q <= rnd1_q;
            sgn2_q <= sgn1_q;
        end
    end

    // Stage 3 register: final result held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q   <= 1'b0;
            man3_q <= '0;
            exp3_q <= '0;
            sgn3_q <= 1'b0;
            ovf3_q <= 1'b0;
        end else if (!stall) begin
            v3_q   <= v2_q;
            man3_q <= man3_d;
            exp3_q <= exp3_d;
            sgn3_q <= sgn2_q;
            ovf3_q <= ovf3_d;
        end
    end

    // Sticky overflow: a delivered saturated result beats a clear.
    always_comb begin
        sticky_d = sticky_q;
        if (ovf_clr) begin
            sticky_d = 1'b0;
        end
        if (out_valid && out_ready && out_ovf) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

endmodule
